// File: rtl/cnn_sdiv_20s_6s_seq.sv
// cnn_sdiv_20s_6s_seq
// Multi-cycle signed divider, 20-bit signed dividend by 6-bit signed divisor,
// giving a saturated 14-bit signed quotient (truncated toward zero) and a
// 6-bit signed remainder whose sign follows the dividend. The core is a
// radix-2 restoring divider working on magnitudes, one quotient bit per
// cycle, wrapped in an ap_start/ap_done/ap_idle/ap_ready block handshake.
// Latency from an accepted ap_start to ap_done is a fixed 22 cycles.

module cnn_sdiv_20s_6s_seq #(
  parameter int din0_WIDTH = 20,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Saturation limits of the 14-bit signed quotient, held in the 21-bit
  // signed domain used for the signed quotient before clamping.
  localparam logic signed [20:0] QMAX = 21'sd8191;
  localparam logic signed [20:0] QMIN = -21'sd8192;

  state_t state;
  state_t next_state;

  // Divider working registers. quo_sh starts as the dividend magnitude and
  // is shifted left each iteration, with quotient bits entering at the LSB,
  // so after 20 iterations it holds the quotient magnitude.
  logic [19:0] quo_sh;
  logic [5:0]  dvs_mag;
  logic [5:0]  prem;
  logic [4:0]  count;
  logic        sign_q;
  logic        sign_r;
  logic        dbz_int;

  // Combinational helpers.
  logic [19:0]        din0_mag;
  logic [5:0]         din1_mag;
  logic [6:0]         trial;
  logic               take;
  logic [5:0]         prem_next;
  logic signed [20:0] q_signed;
  logic [5:0]         r_signed;
  logic [13:0]        dout_fix;
  logic [5:0]         rem_fix;
  logic               ovf_fix;

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the combinational handshake outputs.
  always_comb begin
    next_state = state;
    ap_idle    = 1'b0;
    ap_ready   = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready   = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        if (count == 5'd0) begin
          next_state = FIX;
        end
      end
      FIX: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand magnitudes. A 20-bit unsigned magnitude is enough for -524288,
  // since two's complement negation of 0x80000 yields 0x80000 = 524288.
  always_comb begin
    din0_mag = din0[19] ? (~din0 + 20'd1) : din0;
    din1_mag = din1[5]  ? (~din1 + 6'd1)  : din1;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    trial     = {prem, quo_sh[19]};
    take      = (trial >= {1'b0, dvs_mag});
    prem_next = take ? 6'(trial - {1'b0, dvs_mag}) : trial[5:0];
  end

  // Sign fix-up and saturation of the final quotient and remainder.
  always_comb begin
    q_signed = sign_q ? (21'sd0 - $signed({1'b0, quo_sh}))
                      : $signed({1'b0, quo_sh});
    r_signed = sign_r ? (6'd0 - prem) : prem;
    dout_fix = q_signed[13:0];
    rem_fix  = r_signed;
    ovf_fix  = 1'b0;
    if (dbz_int) begin
      dout_fix = sign_r ? 14'h2000 : 14'h1FFF;
      rem_fix  = 6'd0;
      ovf_fix  = 1'b1;
    end else if (q_signed > QMAX) begin
      dout_fix = 14'h1FFF;
      ovf_fix  = 1'b1;
    end else if (q_signed < QMIN) begin
      dout_fix = 14'h2000;
      ovf_fix  = 1'b1;
    end
  end

  // Datapath: capture on accept, iterate in CALC, register results in FIX.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      quo_sh  <= 20'd0;
      dvs_mag <= 6'd0;
      prem    <= 6'd0;
      count   <= 5'd0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dbz_int <= 1'b0;
      dout    <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      ap_done <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            quo_sh  <= din0_mag;
            dvs_mag <= din1_mag;
            prem    <= 6'd0;
            count   <= 5'd19;
            sign_q  <= din0[19] ^ din1[5];
            sign_r  <= din0[19];
            dbz_int <= (din1 == 6'd0);
          end
        end
        CALC: begin
          prem   <= prem_next;
          quo_sh <= {quo_sh[18:0], take};
          if (count != 5'd0) begin
            count <= count - 5'd1;
          end
        end
        FIX: begin
          dout    <= dout_fix;
          rem     <= rem_fix;
          ovf     <= ovf_fix;
          dbz     <= dbz_int;
          ap_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_sdiv_20s_6s_seq.sv
// tb_cnn_sdiv_20s_6s_seq
// Directed bench for the sequential signed divider: reset state, latency,
// sign handling, saturation, divide by zero, back-to-back issue, reset
// during an operation, and a batch of random operands against a reference
// built from the language's own truncating division.

module tb_cnn_sdiv_20s_6s_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [19:0] din0;
  logic [5:0]  din1;
  logic [13:0] dout;
  logic [5:0]  rem;
  logic        ovf;
  logic        dbz;

  int errors = 0;
  int checks = 0;

  cnn_sdiv_20s_6s_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Issue one operation and wait for ap_done. Returns the handshake values
  // seen in the accept cycle, the latency in cycles, and how many busy
  // cycles showed ap_idle or ap_ready high. Ends on the ap_done negedge.
  task automatic do_op(input int a, input int b, output logic rdy,
                       output logic idl, output int lat, output int viol);
    @(negedge ap_clk);
    din0     = 20'(a);
    din1     = 6'(b);
    ap_start = 1'b1;
    #1;
    rdy = ap_ready;
    idl = ap_idle;
    @(negedge ap_clk);
    ap_start = 1'b0;
    din0     = 20'h5A5A5;
    din1     = 6'h2B;
    lat  = 1;
    viol = 0;
    while (!ap_done && lat < 40) begin
      if (ap_idle || ap_ready) viol++;
      @(negedge ap_clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = 20'd0;
    din1     = 6'd0;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake idle=%b done=%b ready=%b required 1 0 0",
               ap_idle, ap_done, ap_ready);
    end
    checks++;
    if (dout !== 14'd0 || rem !== 6'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs dout=%0d rem=%0d ovf=%b dbz=%b required 0 0 0 0",
               dout, rem, ovf, dbz);
    end
  endtask

  task automatic test_basic;
    logic rdy, idl;
    int lat, viol;
    do_op(1000, 7, rdy, idl, lat, viol);
    checks++;
    if (rdy !== 1'b1 || idl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_accept ready=%b idle=%b required 1 1", rdy, idl);
    end
    checks++;
    if (lat !== 22) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d required 22", lat);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("[TB] FAIL basic_busy_flags got %0d busy cycles with idle/ready, required 0", viol);
    end
    checks++;
    if (dout !== 14'd142 || rem !== 6'd6 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result dout=%0d rem=%0d ovf=%b dbz=%b required 142 6 0 0",
               $signed(dout), $signed(rem), ovf, dbz);
    end
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done_idle idle=%b required 1", ap_idle);
    end
    @(negedge ap_clk);
    checks++;
    if (ap_done !== 1'b0 || dout !== 14'd142) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse done=%b dout=%0d required 0 142",
               ap_done, $signed(dout));
    end
  endtask

  // Sign, exact -8192, saturation and divide-by-zero vectors.
  task automatic test_vectors;
    int va[9]   = '{-1000, 100, -245760, 524287, -524288, -524288, -5, 5, 0};
    int vb[9]   = '{7, -32, 30, 1, -1, 1, 0, 0, -3};
    int eq[9]   = '{-142, -3, -8192, 8191, 8191, -8192, -8192, 8191, 0};
    int er[9]   = '{-6, 4, 0, 0, 0, 0, 0, 0, 0};
    int eo[9]   = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    int ez[9]   = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    logic rdy, idl;
    int lat, viol;
    logic [13:0] exp_q;
    logic [5:0]  exp_r;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vb[i], rdy, idl, lat, viol);
      exp_q = 14'(eq[i]);
      exp_r = 6'(er[i]);
      checks++;
      if (lat !== 22 || rdy !== 1'b1 || viol !== 0) begin
        errors++;
        $display("[TB] FAIL vec%0d_timing lat=%0d ready=%b viol=%0d required 22 1 0",
                 i, lat, rdy, viol);
      end
      checks++;
      if (dout !== exp_q || rem !== exp_r) begin
        errors++;
        $display("[TB] FAIL vec%0d_value %0d/%0d dout=%0d rem=%0d required %0d %0d",
                 i, va[i], vb[i], $signed(dout), $signed(rem), eq[i], er[i]);
      end
      checks++;
      if (ovf !== 1'(eo[i]) || dbz !== 1'(ez[i])) begin
        errors++;
        $display("[TB] FAIL vec%0d_flags ovf=%b dbz=%b required %0d %0d",
                 i, ovf, dbz, eo[i], ez[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic rdy, idl;
    int lat, viol, held_bad;
    do_op(1000, 7, rdy, idl, lat, viol);
    din0     = 20'(77);
    din1     = 6'(-5);
    ap_start = 1'b1;
    #1;
    checks++;
    if (ap_ready !== 1'b1 || ap_idle !== 1'b1 || ap_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept ready=%b idle=%b done=%b required 1 1 1",
               ap_ready, ap_idle, ap_done);
    end
    @(negedge ap_clk);
    ap_start = 1'b0;
    din0     = 20'hFFFFF;
    din1     = 6'h01;
    lat      = 1;
    held_bad = 0;
    while (!ap_done && lat < 40) begin
      if (dout !== 14'd142 || rem !== 6'd6) held_bad++;
      @(negedge ap_clk);
      lat++;
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_hold got %0d cycles with changed result, required 0", held_bad);
    end
    checks++;
    if (lat !== 22) begin
      errors++;
      $display("[TB] FAIL b2b_latency got %0d required 22", lat);
    end
    checks++;
    if (dout !== 14'(-15) || rem !== 6'd2 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_result dout=%0d rem=%0d ovf=%b required -15 2 0",
               $signed(dout), $signed(rem), ovf);
    end
  endtask

  task automatic test_reset_mid;
    logic rdy, idl;
    int lat, viol, dones;
    @(negedge ap_clk);
    din0     = 20'(-1000);
    din1     = 6'd7;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (9) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_state idle=%b done=%b required 1 0", ap_idle, ap_done);
    end
    checks++;
    if (dout !== 14'd0 || rem !== 6'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs dout=%0d rem=%0d ovf=%b dbz=%b required 0 0 0 0",
               dout, rem, ovf, dbz);
    end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (ap_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_no_done got %0d done pulses required 0", dones);
    end
    do_op(-77, 5, rdy, idl, lat, viol);
    checks++;
    if (lat !== 22 || dout !== 14'(-15) || rem !== 6'(-2)) begin
      errors++;
      $display("[TB] FAIL midrst_fresh lat=%0d dout=%0d rem=%0d required 22 -15 -2",
               lat, $signed(dout), $signed(rem));
    end
  endtask

  task automatic test_random;
    logic rdy, idl;
    int lat, viol, a, b, q, r;
    logic eo, ez;
    for (int n = 0; n < 300; n++) begin
      a = int'($urandom_range(1048575, 0)) - 524288;
      b = int'($urandom_range(63, 0)) - 32;
      if (n % 50 == 0) b = 0;
      if (b == 0) begin
        q  = (a < 0) ? -8192 : 8191;
        r  = 0;
        eo = 1'b1;
        ez = 1'b1;
      end else begin
        q  = a / b;
        r  = a % b;
        eo = 1'b0;
        ez = 1'b0;
        if (q > 8191) begin
          q  = 8191;
          eo = 1'b1;
        end else if (q < -8192) begin
          q  = -8192;
          eo = 1'b1;
        end
      end
      do_op(a, b, rdy, idl, lat, viol);
      checks++;
      if (lat !== 22 || rdy !== 1'b1 || idl !== 1'b1 || viol !== 0) begin
        errors++;
        $display("[TB] FAIL rand%0d_timing lat=%0d ready=%b idle=%b viol=%0d required 22 1 1 0",
                 n, lat, rdy, idl, viol);
      end
      checks++;
      if (dout !== 14'(q) || rem !== 6'(r) || ovf !== eo || dbz !== ez) begin
        errors++;
        $display("[TB] FAIL rand%0d_value %0d/%0d dout=%0d rem=%0d ovf=%b dbz=%b required %0d %0d %b %b",
                 n, a, b, $signed(dout), $signed(rem), ovf, dbz, q, r, eo, ez);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
